// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: DATA_W-bit words, CLK_DIV clk cycles per SCK half-period,
// all four CKP/CPH modes. Optional macro SPI_LSB_FIRST_EN adds a lsb_first input latched at accept.
module spi_master_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              strt,
  input  logic [DATA_W-1:0] data,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic              CS,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned HpW = $clog2(CLK_DIV + 1);
  localparam int unsigned EcW = $clog2(2 * DATA_W + 1);
  localparam logic [HpW-1:0] HpLast = HpW'(CLK_DIV - 1);
  localparam logic [EcW-1:0] EcLast = EcW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} state_e;

  state_e            state_q, state_d;
  logic [HpW-1:0]    hp_q, hp_d;
  logic [EcW-1:0]    edge_q, edge_d;
  logic              ckp_q, ckp_d;
  logic              cph_q, cph_d;
  logic              lsb_q, lsb_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              mosi_q, mosi_d;
  logic              sck_q, sck_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              do_edge;
  logic [EcW-1:0]    edge_idx;
  logic              lsb_in;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  // LSB-first fills from the top so the first sampled bit ends in bit 0.
  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic lsb,
                                                 input logic b);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    edge_d   = edge_q;
    ckp_d    = ckp_q;
    cph_d    = cph_q;
    lsb_d    = lsb_q;
    tx_d     = tx_q;
    rx_sh_d  = rx_sh_q;
    rx_d     = rx_q;
    mosi_d   = mosi_q;
    sck_d    = sck_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    do_edge  = 1'b0;
    edge_idx = '0;

    unique case (state_q)
      StIdle: begin
        sck_d = CKP;
        cs_d  = 1'b1;
        if (strt) begin
          state_d = StLead;
          ckp_d   = CKP;
          cph_d   = CPH;
          lsb_d   = lsb_in;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          hp_d    = '0;
          edge_d  = '0;
          rx_sh_d = '0;
          if (CPH) begin
            tx_d = data;
          end else begin
            mosi_d = out_bit(data, lsb_in);
            tx_d   = shift_tx(data, lsb_in);
          end
        end
      end
      StLead: begin
        sck_d = ckp_q;
        if (hp_q == HpLast) begin
          hp_d     = '0;
          edge_d   = '0;
          state_d  = StXfer;
          sck_d    = ~ckp_q;
          do_edge  = 1'b1;
          edge_idx = '0;
        end else begin
          hp_d = hp_q + HpW'(1);
        end
      end
      StXfer: begin
        if (hp_q == HpLast) begin
          hp_d = '0;
          if (edge_q == EcLast) begin
            state_d = StTrail;
          end else begin
            edge_d   = edge_q + EcW'(1);
            sck_d    = ~sck_q;
            do_edge  = 1'b1;
            edge_idx = edge_q + EcW'(1);
          end
        end else begin
          hp_d = hp_q + HpW'(1);
        end
      end
      StTrail: begin
        sck_d = ckp_q;
        if (hp_q == HpLast) begin
          state_d = StIdle;
          hp_d    = '0;
          edge_d  = '0;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          mosi_d  = 1'b0;
          sck_d   = CKP;
        end else begin
          hp_d = hp_q + HpW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Even edge_idx is a leading edge; CPH selects which edge kind samples.
    if (do_edge) begin
      if ((~edge_idx[0]) ^ cph_q) begin
        rx_sh_d = shift_rx(rx_sh_q, lsb_q, MISO);
      end else if (!(!cph_q && edge_idx == EcLast)) begin
        mosi_d = out_bit(tx_q, lsb_q);
        tx_d   = shift_tx(tx_q, lsb_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      hp_q    <= '0;
      edge_q  <= '0;
      ckp_q   <= 1'b0;
      cph_q   <= 1'b0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      edge_q  <= edge_d;
      ckp_q   <= ckp_d;
      cph_q   <= cph_d;
      lsb_q   <= lsb_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      mosi_q  <= mosi_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign MOSI    = mosi_q;
  assign SCK     = sck_q;
  assign CS      = cs_q;
  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
